seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  signed two's-complement numerator.
REQ-006 divisor  input  WIDTH  signed two's-complement denominator.
REQ-007 quotient  output  WIDTH  signed result, registered.
REQ-008 remainder  output  WIDTH  signed result, registered.
REQ-009 busy  output  1  high in CALC and FIXSIGN.
REQ-010 done  output  1  high only in DONE.
REQ-011 divZero  output  1  divisor was zero; valid while done.
REQ-012 ovf  output  1  quotient not representable; valid while done.

Function
REQ-013 The FSM SHALL have four states: IDLE, CALC, FIXSIGN, DONE.
REQ-014 IDLE: start=1 with nonzero divisor SHALL latch operand magnitudes and signs, clear the partial remainder and step counter, and go to CALC.
REQ-015 IDLE: start=1 with divisor=0 SHALL go directly to DONE with quotient all-ones, remainder=dividend, divZero=1, ovf=0.
REQ-016 CALC: each cycle SHALL perform one restoring step: shift {remainder,quotient} left 1, subtract |divisor| from the remainder, keep the difference and set quotient LSB=1 if it is non-negative, otherwise restore and set LSB=0.
REQ-017 CALC SHALL last exactly WIDTH cycles, then go to FIXSIGN.
REQ-018 The partial remainder SHALL be WIDTH+1 bits wide.
REQ-019 Magnitudes SHALL be WIDTH-bit unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
REQ-020 FIXSIGN (1 cycle) SHALL negate the quotient if sign(dividend) XOR sign(divisor), and SHALL negate the remainder if the dividend is negative (truncating division).
REQ-021 ovf SHALL be 1 only for dividend = -2^(WIDTH-1) and divisor = -1; quotient then wraps to -2^(WIDTH-1) and remainder is 0.
REQ-022 DONE SHALL stay while start=1 and SHALL return to IDLE on start=0.
REQ-023 Latency: start sampled at edge N gives done=1 after edge N+WIDTH+2; the divide-by-zero path gives done=1 after edge N+1.
REQ-024 start asserted in CALC or FIXSIGN SHALL be ignored, and operands changing mid-operation SHALL NOT affect the result.
REQ-025 quotient, remainder, divZero and ovf SHALL hold their values from DONE until the next accepted start, which clears divZero and ovf.
REQ-026 busy and done SHALL never be high together.

Reset
REQ-027 reset_L=0 SHALL force IDLE immediately, including mid-operation, and the aborted result SHALL be discarded.
REQ-028 On reset, quotient, remainder, busy, done, divZero, ovf and the step counter SHALL all be 0.
REQ-029 The first start after reset_L rises SHALL be handled as a normal request.

Structure
REQ-030 Package div_pkg SHALL hold the state enum typedef (IDLE, CALC, FIXSIGN, DONE) and the default WIDTH constant.
REQ-031 The datapath (operand and sign registers, shift/subtract/restore, step counter, sign fix) SHALL be sub-module div_datapath, controlled by the FSM in seq_divider.
REQ-032 The step counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-033 100 / 7 (WIDTH=8), start at edge 0 -> done after edge 10; quotient=14, remainder=2, divZero=0, ovf=0.
REQ-034 -100 / 7 -> quotient=-14 (8'hF2), remainder=-2 (8'hFE); 100 / -7 -> quotient=-14, remainder=2.
REQ-035 7 / 0 -> done after edge 1; quotient=8'hFF, remainder=7, divZero=1, busy never high.
REQ-036 -128 / -1 -> quotient=8'h80, remainder=0, ovf=1; -128 / 1 -> quotient=8'h80, ovf=0.
REQ-037 start held high through the operation with dividend changed to 50 mid-CALC -> result still for 100/7; done held until start=0, then IDLE.
REQ-038 reset_L pulsed low at CALC step 4 -> all outputs 0 at once; a new 9/2 request -> quotient=4, remainder=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Imported by the FSM top and its datapath.
package div_pkg;

    // Default operand/result width in bits.
    localparam int DefaultWidth = 8;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXSIGN,
        DONE
    } divState_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: operand latch, shift/subtract,
// step counter and final sign fix, sequenced by seq_divider.
import div_pkg::*;

module div_datapath #(
    parameter int WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             load,
    input  logic             loadZero,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             divisorZero,
    output logic             lastStep,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divZero,
    output logic             ovf
);

    localparam int CntW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] absDvs;
    logic [WIDTH-1:0] workQuo;
    logic [WIDTH:0]   partRem;
    logic [CntW-1:0]  stepCnt;
    logic             negQ;
    logic             negR;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   nextRem;
    logic [WIDTH-1:0] nextQuo;

    // Unsigned magnitude; the most negative value maps exactly.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign divisorZero = (divisor == '0);
    assign lastStep    = (stepCnt == CntW'(WIDTH - 1));

    // One restoring step: shift in next dividend bit, trial subtract.
    always_comb begin
        shifted = {partRem[WIDTH-1:0], workQuo[WIDTH-1]};
        diff    = shifted - {1'b0, absDvs};
        if (!diff[WIDTH]) begin
            nextRem = diff;
            nextQuo = {workQuo[WIDTH-2:0], 1'b1};
        end else begin
            nextRem = shifted;
            nextQuo = {workQuo[WIDTH-2:0], 1'b0};
        end
    end

    // Datapath registers, loaded according to the controller strobes.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            absDvs    <= '0;
            workQuo   <= '0;
            partRem   <= '0;
            stepCnt   <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divZero   <= 1'b0;
            ovf       <= 1'b0;
        end else if (load) begin
            absDvs  <= mag(divisor);
            workQuo <= mag(dividend);
            partRem <= '0;
            stepCnt <= '0;
            negQ    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negR    <= dividend[WIDTH-1];
            divZero <= 1'b0;
            ovf     <= 1'b0;
        end else if (loadZero) begin
            quotient  <= '1;
            remainder <= dividend;
            divZero   <= 1'b1;
            ovf       <= 1'b0;
        end else if (step) begin
            partRem <= nextRem;
            workQuo <= nextQuo;
            stepCnt <= stepCnt + 1'b1;
        end else if (fix) begin
            quotient  <= negQ ? (~workQuo + 1'b1) : workQuo;
            remainder <= negR ? (~partRem[WIDTH-1:0] + 1'b1)
                              : partRem[WIDTH-1:0];
            // A positive quotient with the top bit set only arises
            // from the most negative dividend divided by -1.
            ovf       <= !negQ && workQuo[WIDTH-1];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Signed sequential divider: controller FSM around div_datapath.
// One quotient bit per CALC cycle, truncating toward zero.
import div_pkg::*;

module seq_divider #(
    parameter int WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic             ovf
);

    divState_t state;
    divState_t nextState;

    logic load;
    logic loadZero;
    logic step;
    logic fix;
    logic divisorZero;
    logic lastStep;

    div_datapath #(
        .WIDTH(WIDTH)
    ) datapath (
        .clock      (clock),
        .reset_L    (reset_L),
        .load       (load),
        .loadZero   (loadZero),
        .step       (step),
        .fix        (fix),
        .dividend   (dividend),
        .divisor    (divisor),
        .divisorZero(divisorZero),
        .lastStep   (lastStep),
        .quotient   (quotient),
        .remainder  (remainder),
        .divZero    (divZero),
        .ovf        (ovf)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        nextState = state;
        load      = 1'b0;
        loadZero  = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (divisorZero) begin
                        loadZero  = 1'b1;
                        nextState = DONE;
                    end else begin
                        load      = 1'b1;
                        nextState = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (lastStep) begin
                    nextState = FIXSIGN;
                end
            end
            FIXSIGN: begin
                fix       = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                if (!start) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == FIXSIGN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed corners
// plus random operands against an integer-arithmetic reference.
module tb_seq_divider;

    logic       clock;
    logic       reset_L;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       divZero;
    logic       ovf;

    int compared = 0;
    int mismatched = 0;

    seq_divider #(
        .WIDTH(8)
    ) dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .divZero  (divZero),
        .ovf      (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check8(input string tag, input logic [7:0] o,
                          input logic [7:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check1(input string tag, input logic o, input logic e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
        end
    endtask

    task automatic checkI(input string tag, input int o, input int e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Reference: truncating signed division on plain integers.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output logic o);
        int sa;
        int sb;
        int iq;
        int ir;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
            o = 1'b0;
        end else begin
            iq = sa / sb;
            ir = sa % sb;
            q = iq[7:0];
            r = ir[7:0];
            z = 1'b0;
            o = (iq > 127) || (iq < -128);
        end
    endtask

    // Issue one request, holding start through the operation.
    task automatic doDiv(input logic [7:0] a, input logic [7:0] b,
                         input bit scramble, input int hold);
        logic [7:0] eq;
        logic [7:0] er;
        logic ez;
        logic eo;
        int lat;
        bit sawBusy;
        bit both;
        model(a, b, eq, er, ez, eo);
        @(posedge clock);
        #1;
        start = 1'b1;
        dividend = a;
        divisor = b;
        lat = 0;
        sawBusy = 0;
        both = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
            if (busy) sawBusy = 1;
            if (busy && done) both = 1;
            if (scramble && lat == 3) begin
                dividend = 8'd50;
                divisor = 8'($urandom);
            end
        end
        checkI("latency", lat, (b == 8'd0) ? 1 : 10);
        check8("quotient", quotient, eq);
        check8("remainder", remainder, er);
        check1("divZero", divZero, ez);
        check1("ovf", ovf, eo);
        check1("busySeen", sawBusy, b != 8'd0);
        check1("busyAndDone", both, 1'b0);
        repeat (hold) @(posedge clock);
        #1;
        if (hold > 0) check1("doneHeld", done, 1'b1);
        start = 1'b0;
        @(posedge clock);
        #1;
        check1("doneClear", done, 1'b0);
        check8("quotientHold", quotient, eq);
        check8("remainderHold", remainder, er);
    endtask

    initial begin
        reset_L = 1'b0;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        #1;
        check8("rstQuotient", quotient, 8'd0);
        check8("rstRemainder", remainder, 8'd0);
        check1("rstBusy", busy, 1'b0);
        check1("rstDone", done, 1'b0);
        check1("rstDivZero", divZero, 1'b0);
        check1("rstOvf", ovf, 1'b0);
        repeat (2) @(negedge clock);
        reset_L = 1'b1;

        doDiv(8'd100, 8'd7, 0, 0);
        doDiv(8'(-100), 8'd7, 0, 0);
        doDiv(8'd100, 8'(-7), 0, 0);
        doDiv(8'd7, 8'd0, 0, 0);
        doDiv(8'h80, 8'hFF, 0, 0);
        doDiv(8'h80, 8'd1, 0, 0);
        doDiv(8'd100, 8'd7, 1, 3);

        // Abort mid-calculation with reset.
        @(posedge clock);
        #1;
        start = 1'b1;
        dividend = 8'd100;
        divisor = 8'd7;
        repeat (5) @(posedge clock);
        #2;
        start = 1'b0;
        check1("midBusy", busy, 1'b1);
        reset_L = 1'b0;
        #1;
        check8("abortQuotient", quotient, 8'd0);
        check8("abortRemainder", remainder, 8'd0);
        check1("abortBusy", busy, 1'b0);
        check1("abortDone", done, 1'b0);
        check1("abortDivZero", divZero, 1'b0);
        check1("abortOvf", ovf, 1'b0);
        @(negedge clock);
        reset_L = 1'b1;
        doDiv(8'd9, 8'd2, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            doDiv(ra, rb, i[0], i % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
